// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: encodes symbolic instruction beats into MIPS words and streams them into imem.
// One-entry registered write stage with backpressure, sequenced by an IDLE/RUN/DRAIN/DONE FSM.
module mips_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [25:0]       in_imm,
   input  logic              in_last,
   output logic              im_we,
   input  logic              im_ready,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words,
   output logic [1:0]        err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [ADDR_W:0] MAX = MAX_WORDS[ADDR_W:0];
   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   words_next;
   logic [5:0]        func, op;
   logic [31:0]       enc;
   logic              fire, accept, legal, full, shift, jr, lui;
   assign fire       = im_we & im_ready;
   assign in_ready   = (state == RUN) & (~im_we | im_ready);
   assign accept     = in_valid & in_ready;
   assign busy       = state != IDLE;
   assign legal      = in_mnem < 5'd24;
   assign words_next = words + {{ADDR_W{1'b0}}, fire};
   // capacity counts the word still pending in the output stage
   assign full       = (words + {{ADDR_W{1'b0}}, im_we}) >= MAX;
   always_comb begin
      func = 6'h00;
      op   = 6'h00;
      case (in_mnem)
         5'd0:  func = 6'h20;
         5'd1:  func = 6'h22;
         5'd2:  func = 6'h24;
         5'd3:  func = 6'h25;
         5'd4:  func = 6'h26;
         5'd5:  func = 6'h00;
         5'd6:  func = 6'h02;
         5'd7:  func = 6'h03;
         5'd8:  func = 6'h08;
         5'd9:  func = 6'h18;
         5'd10: func = 6'h1a;
         5'd11: func = 6'h2a;
         5'd12: func = 6'h3f;
         5'd13: op   = 6'h08;
         5'd14: op   = 6'h0c;
         5'd15: op   = 6'h0d;
         5'd16: op   = 6'h0e;
         5'd17: op   = 6'h23;
         5'd18: op   = 6'h2b;
         5'd19: op   = 6'h04;
         5'd20: op   = 6'h05;
         5'd21: op   = 6'h0f;
         5'd22: op   = 6'h02;
         5'd23: op   = 6'h03;
         default: ;
      endcase
      shift = (in_mnem >= 5'd5) && (in_mnem <= 5'd7);
      jr    = in_mnem == 5'd8;
      lui   = in_mnem == 5'd21;
      enc   = in_mnem < 5'd13 ? {6'b0, shift ? 5'b0 : in_rs, jr ? 5'b0 : in_rt, jr ? 5'b0 : in_rd,
                                 shift ? in_shamt : 5'b0, func}
            : in_mnem < 5'd22 ? {op, lui ? 5'b0 : in_rs, in_rt, in_imm[15:0]}
            : {op, in_imm};
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= IDLE;
         base     <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         words    <= '0;
         err      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fire) begin
            words <= words_next;
            im_we <= 1'b0;
         end
         case (state)
            IDLE: if (start) begin
               base  <= base_addr;
               words <= '0;
               err   <= '0;
               state <= RUN;
            end
            RUN: begin
               if (accept && legal && !full) begin
                  im_we    <= 1'b1;
                  im_wdata <= enc;
                  im_addr  <= base + words_next[ADDR_W-1:0];
               end
               if (accept && !legal) err[0] <= 1'b1;
               if (accept && legal && full) err[1] <= 1'b1;
               if (accept && in_last) state <= DRAIN;
            end
            DRAIN: if (!im_we || fire) begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
